// File: rtl/vdma_sched_pkg.sv
// Shared definitions for the vdma frame-buffer scheduler.
// Contents:
//   buf_state_t   - per-buffer ownership state (FREE/WRITING/READY/READING)
//   sched_state_t - top-level scheduler state
//   buf_addr()    - buffer start address = base + idx*pitch (shift-add)
package vdma_sched_pkg;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

  // Wide enough for any realistic address bus; callers truncate the result,
  // which gives the modulo-2**ADDR_WIDTH wrap for free.
  localparam int ADDR_CALC_W = 64;

  // Shift-add on a 2-bit index avoids a general multiplier.
  function automatic logic [ADDR_CALC_W-1:0] buf_addr(
    input logic [ADDR_CALC_W-1:0] base,
    input logic [ADDR_CALC_W-1:0] pitch,
    input logic [1:0]             idx
  );
    logic [ADDR_CALC_W-1:0] sum;
    case (idx)
      2'd0:    sum = base;
      2'd1:    sum = base + pitch;
      2'd2:    sum = base + (pitch << 1);
      2'd3:    sum = base + (pitch << 1) + pitch;
      default: sum = base;
    endcase
    return sum;
  endfunction

endpackage

// File: rtl/vdma_buf_alloc.sv
// Per-buffer ownership tracker for the frame scheduler.
// Ports:
//   aclk, rst     - clock, async active-low reset
//   clear         - return every buffer to FREE
//   take          - grant accepted: lowest FREE buffer becomes WRITING
//   done          - writer finished its frame (ignored if nothing WRITING)
//   first         - this done is the very first frame: go straight to READING
//   swap          - reader frame boundary while running
//   writing       - some buffer is WRITING
//   any_free      - some buffer is FREE
//   free_idx      - lowest-index FREE buffer
//   rd_next_idx   - buffer that will be READING after this cycle's events
//   drop, rep     - a READY frame was overwritten / the reader repeats a frame
module vdma_buf_alloc
  import vdma_sched_pkg::*;
#(
  parameter int NUM_BUFS = 3,
  parameter int IDX_W    = 2
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             take,
  input  logic             done,
  input  logic             first,
  input  logic             swap,
  output logic             writing,
  output logic             any_free,
  output logic [IDX_W-1:0] free_idx,
  output logic [IDX_W-1:0] rd_next_idx,
  output logic             drop,
  output logic             rep
);

  buf_state_t       st_r  [NUM_BUFS];
  buf_state_t       st_nx [NUM_BUFS];
  logic             r_any_s;
  logic             done_ev_s;
  logic [IDX_W-1:0] w_idx_s, r_idx_s, rd_idx_s;

  // Scan the state array; descending loop so the lowest FREE index wins.
  always_comb begin
    writing  = 1'b0;
    r_any_s  = 1'b0;
    any_free = 1'b0;
    w_idx_s  = '0;
    r_idx_s  = '0;
    rd_idx_s = '0;
    free_idx = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      case (st_r[i])
        BUF_FREE:    begin any_free = 1'b1; free_idx = IDX_W'(i); end
        BUF_WRITING: begin writing  = 1'b1; w_idx_s  = IDX_W'(i); end
        BUF_READY:   begin r_any_s  = 1'b1; r_idx_s  = IDX_W'(i); end
        BUF_READING: rd_idx_s = IDX_W'(i);
        default:     rd_idx_s = rd_idx_s;
      endcase
    end
  end

  // Apply grant, write completion and reader boundary; completion goes first
  // so a same-cycle boundary picks up the frame that just finished.
  always_comb begin
    st_nx       = st_r;
    done_ev_s   = done && writing;
    drop        = done_ev_s && !first && r_any_s;
    rep         = swap && !done_ev_s && !r_any_s;
    rd_next_idx = rd_idx_s;
    if (clear) begin
      for (int i = 0; i < NUM_BUFS; i++) st_nx[i] = BUF_FREE;
    end else begin
      if (take && any_free && !writing) st_nx[free_idx] = BUF_WRITING;
      else                              st_nx[free_idx] = st_nx[free_idx];
      if (done_ev_s && first) begin
        st_nx[w_idx_s] = BUF_READING;
        rd_next_idx    = w_idx_s;
      end else if (done_ev_s) begin
        if (r_any_s) st_nx[r_idx_s] = BUF_FREE;
        else         st_nx[r_idx_s] = st_nx[r_idx_s];
        st_nx[w_idx_s] = BUF_READY;
      end else begin
        st_nx[w_idx_s] = st_nx[w_idx_s];
      end
      if (swap && done_ev_s) begin
        st_nx[rd_idx_s] = BUF_FREE;
        st_nx[w_idx_s]  = BUF_READING;
        rd_next_idx     = w_idx_s;
      end else if (swap && r_any_s) begin
        st_nx[rd_idx_s] = BUF_FREE;
        st_nx[r_idx_s]  = BUF_READING;
        rd_next_idx     = r_idx_s;
      end else begin
        rd_next_idx = rd_next_idx;
      end
    end
  end

  // Buffer state register.
  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BUFS; i++) st_r[i] <= BUF_FREE;
    end else begin
      st_r <= st_nx;
    end
  end

endmodule

// File: rtl/vdma_sched_chk.sv
// Simulation checks for the frame scheduler.
// Ports:
//   aclk, rst - clock, async active-low reset
//   take_req  - a write grant is being requested this cycle
//   any_free  - a FREE buffer exists
module vdma_sched_chk (
  input logic aclk,
  input logic rst,
  input logic take_req,
  input logic any_free
);

  // With three or more buffers and none WRITING, one must always be FREE.
  a_free_on_grant: assert property (@(posedge aclk) disable iff (!rst)
    !(take_req && !any_free));

endmodule

// File: rtl/vdma_frame_sched.sv
// Frame-buffer scheduler between a frame writer and the vdma frame reader.
// Hands FREE buffers to the writer, promotes completed frames, and at every
// reader frame boundary points the reader at the newest completed frame.
// Ports:
//   aclk, rst           - clock, async active-low reset
//   ctrl_*              - run enable, buffer geometry, reader geometry
//   wr_req/wr_grant/wr_addr/wr_done - writer buffer handshake
//   rd_frame_done       - reader finished a frame
//   cfg_*               - reader configuration (changes only at frame edges)
//   stat_*              - current indices and saturating drop/repeat counts
//   busy                - scheduler not idle
module vdma_frame_sched
  import vdma_sched_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_BUFS     = 3,
  parameter int IDX_W        = 2,
  parameter int LINE_COUNT   = 12,
  parameter int STRIDE_COUNT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    ctrl_enable,
  input  logic [ADDR_WIDTH-1:0]   ctrl_base_addr,
  input  logic [ADDR_WIDTH-1:0]   ctrl_frame_bytes,
  input  logic [LINE_COUNT-1:0]   ctrl_frame_lines,
  input  logic [STRIDE_COUNT-1:0] ctrl_line_stride,
  input  logic [LINE_COUNT-1:0]   ctrl_line_words,
  input  logic                    wr_req,
  output logic                    wr_grant,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic                    wr_done,
  input  logic                    rd_frame_done,
  output logic                    cfg_active,
  output logic [ADDR_WIDTH-1:0]   cfg_frame_addr,
  output logic [LINE_COUNT-1:0]   cfg_frame_lines,
  output logic [STRIDE_COUNT-1:0] cfg_line_stride,
  output logic [LINE_COUNT-1:0]   cfg_line_words,
  output logic [IDX_W-1:0]        stat_rd_idx,
  output logic [IDX_W-1:0]        stat_wr_idx,
  output logic [CNT_W-1:0]        stat_drop_cnt,
  output logic [CNT_W-1:0]        stat_rep_cnt,
  output logic                    busy
);

  sched_state_t            state_r, state_nx;
  logic [ADDR_WIDTH-1:0]   lat_base_r, lat_pitch_r;
  logic [LINE_COUNT-1:0]   lat_lines_r, lat_words_r;
  logic [STRIDE_COUNT-1:0] lat_stride_r;
  logic                    take_req_s, accept_s, first_s, swap_s, clear_s;
  logic                    writing_s, any_free_s, drop_s, rep_s;
  logic [IDX_W-1:0]        free_idx_s, rd_next_s;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx);
    return ADDR_WIDTH'(buf_addr(ADDR_CALC_W'(lat_base_r), ADDR_CALC_W'(lat_pitch_r), 2'(idx)));
  endfunction

  assign take_req_s = wr_req && !writing_s && (state_r == ST_WAIT1 || state_r == ST_RUN);
  assign accept_s   = take_req_s && any_free_s;
  assign first_s    = (state_r == ST_WAIT1) && wr_done && writing_s;
  assign swap_s     = (state_r == ST_RUN) && rd_frame_done;
  assign clear_s    = (state_r == ST_DRAIN) && (state_nx == ST_IDLE);

  vdma_buf_alloc #(.NUM_BUFS(NUM_BUFS), .IDX_W(IDX_W)) u_alloc (
    .aclk        (aclk),
    .rst         (rst),
    .clear       (clear_s),
    .take        (accept_s),
    .done        (wr_done),
    .first       (first_s),
    .swap        (swap_s),
    .writing     (writing_s),
    .any_free    (any_free_s),
    .free_idx    (free_idx_s),
    .rd_next_idx (rd_next_s),
    .drop        (drop_s),
    .rep         (rep_s)
  );

  vdma_sched_chk u_chk (
    .aclk     (aclk),
    .rst      (rst),
    .take_req (take_req_s),
    .any_free (any_free_s)
  );

  // Scheduler next state; DRAIN waits for the writer and the reader to finish.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:  if (ctrl_enable) state_nx = ST_WAIT1; else state_nx = ST_IDLE;
      ST_WAIT1: if (!ctrl_enable) state_nx = ST_DRAIN;
                else if (first_s) state_nx = ST_RUN;
                else state_nx = ST_WAIT1;
      ST_RUN:   if (!ctrl_enable) state_nx = ST_DRAIN; else state_nx = ST_RUN;
      ST_DRAIN: if (!writing_s && !cfg_active) state_nx = ST_IDLE; else state_nx = ST_DRAIN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register and control latch taken when leaving IDLE.
  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      lat_base_r   <= '0;
      lat_pitch_r  <= '0;
      lat_lines_r  <= '0;
      lat_stride_r <= '0;
      lat_words_r  <= '0;
    end else begin
      state_r <= state_nx;
      if (state_r == ST_IDLE && ctrl_enable) begin
        lat_base_r   <= ctrl_base_addr;
        lat_pitch_r  <= ctrl_frame_bytes;
        lat_lines_r  <= ctrl_frame_lines;
        lat_stride_r <= ctrl_line_stride;
        lat_words_r  <= ctrl_line_words;
      end
    end
  end

  // Writer/reader interface registers, status and saturating counters.
  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      wr_grant        <= 1'b0;
      wr_addr         <= '0;
      cfg_active      <= 1'b0;
      cfg_frame_addr  <= '0;
      cfg_frame_lines <= '0;
      cfg_line_stride <= '0;
      cfg_line_words  <= '0;
      stat_rd_idx     <= '0;
      stat_wr_idx     <= '0;
      stat_drop_cnt   <= '0;
      stat_rep_cnt    <= '0;
      busy            <= 1'b0;
    end else begin
      wr_grant <= accept_s;
      busy     <= (state_nx != ST_IDLE);
      if (accept_s) begin
        wr_addr     <= addr_of(free_idx_s);
        stat_wr_idx <= free_idx_s;
      end
      if (first_s || swap_s) begin
        cfg_frame_addr <= addr_of(rd_next_s);
        stat_rd_idx    <= rd_next_s;
      end
      // First frame uses the geometry captured at enable; later frame edges
      // pick up whatever the controller is presenting at that moment.
      if (first_s) begin
        cfg_frame_lines <= lat_lines_r;
        cfg_line_stride <= lat_stride_r;
        cfg_line_words  <= lat_words_r;
      end else if (swap_s) begin
        cfg_frame_lines <= ctrl_frame_lines;
        cfg_line_stride <= ctrl_line_stride;
        cfg_line_words  <= ctrl_line_words;
      end
      if (first_s) cfg_active <= 1'b1;
      else if (state_r == ST_DRAIN && rd_frame_done) cfg_active <= 1'b0;
      if (clear_s) begin
        stat_rd_idx <= '0;
        stat_wr_idx <= '0;
      end
      if (drop_s && stat_drop_cnt != {CNT_W{1'b1}}) stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
      if (rep_s && stat_rep_cnt != {CNT_W{1'b1}}) stat_rep_cnt <= stat_rep_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vdma_frame_sched.sv
// Directed bench for vdma_frame_sched with a per-cycle reference model that
// tracks which buffer is being written, which is waiting, and which is read.
module tb_vdma_frame_sched;

  localparam int NB = 3;

  logic        aclk = 1'b0;
  logic        rst = 1'b0;
  logic        ctrl_enable = 1'b0;
  logic [31:0] ctrl_base_addr = 32'h1000_0000;
  logic [31:0] ctrl_frame_bytes = 32'h0010_0000;
  logic [11:0] ctrl_frame_lines = 12'd480;
  logic [15:0] ctrl_line_stride = 16'd2560;
  logic [11:0] ctrl_line_words = 12'd320;
  logic        wr_req = 1'b0, wr_done = 1'b0, rd_frame_done = 1'b0;
  logic        wr_grant, cfg_active, busy;
  logic [31:0] wr_addr, cfg_frame_addr;
  logic [11:0] cfg_frame_lines, cfg_line_words;
  logic [15:0] cfg_line_stride, stat_drop_cnt, stat_rep_cnt;
  logic [1:0]  stat_rd_idx, stat_wr_idx;

  int tests = 0;
  int fails = 0;

  vdma_frame_sched dut (
    .aclk(aclk), .rst(rst), .ctrl_enable(ctrl_enable),
    .ctrl_base_addr(ctrl_base_addr), .ctrl_frame_bytes(ctrl_frame_bytes),
    .ctrl_frame_lines(ctrl_frame_lines), .ctrl_line_stride(ctrl_line_stride),
    .ctrl_line_words(ctrl_line_words), .wr_req(wr_req), .wr_grant(wr_grant),
    .wr_addr(wr_addr), .wr_done(wr_done), .rd_frame_done(rd_frame_done),
    .cfg_active(cfg_active), .cfg_frame_addr(cfg_frame_addr),
    .cfg_frame_lines(cfg_frame_lines), .cfg_line_stride(cfg_line_stride),
    .cfg_line_words(cfg_line_words), .stat_rd_idx(stat_rd_idx),
    .stat_wr_idx(stat_wr_idx), .stat_drop_cnt(stat_drop_cnt),
    .stat_rep_cnt(stat_rep_cnt), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Model: mode 0 idle, 1 waiting for first frame, 2 running, 3 draining.
  // Buffer roles held as indices, -1 meaning "no such buffer".
  int          m_mode, m_wi, m_ri, m_rdi;
  logic [31:0] m_base, m_pitch;
  logic [11:0] m_lines, m_words;
  logic [15:0] m_stride;
  logic        e_grant, e_active, e_busy;
  logic [31:0] e_wr_addr, e_cfg_addr;
  logic [11:0] e_lines, e_words;
  logic [15:0] e_stride, e_drop, e_rep;
  logic [1:0]  e_rd_idx, e_wr_idx;

  task automatic m_reset();
    m_mode = 0; m_wi = -1; m_ri = -1; m_rdi = -1;
    m_base = 32'd0; m_pitch = 32'd0; m_lines = 12'd0; m_words = 12'd0; m_stride = 16'd0;
    e_grant = 1'b0; e_active = 1'b0; e_busy = 1'b0; e_wr_addr = 32'd0; e_cfg_addr = 32'd0;
    e_lines = 12'd0; e_words = 12'd0; e_stride = 16'd0; e_drop = 16'd0; e_rep = 16'd0;
    e_rd_idx = 2'd0; e_wr_idx = 2'd0;
  endtask

  // Expected outputs after the coming clock edge, from the current inputs.
  task automatic model_step();
    int  nmode, g;
    bit  done_ev, old_active;
    nmode = m_mode;
    old_active = e_active;
    e_grant = 1'b0;
    if (wr_req && m_wi < 0 && (m_mode == 1 || m_mode == 2)) begin
      g = -1;
      for (int b = NB - 1; b >= 0; b--) if (b != m_ri && b != m_rdi) g = b;
      e_grant = 1'b1;
      e_wr_addr = m_base + 32'(g) * m_pitch;
      e_wr_idx = 2'(g);
      m_wi = g;
    end else begin
      done_ev = wr_done && m_wi >= 0;
      if (done_ev && m_mode == 1) begin
        m_rdi = m_wi;
        e_active = 1'b1;
        e_cfg_addr = m_base + 32'(m_wi) * m_pitch;
        e_rd_idx = 2'(m_wi);
        e_lines = m_lines; e_stride = m_stride; e_words = m_words;
        nmode = ctrl_enable ? 2 : 3;
      end else if (done_ev) begin
        if (m_ri >= 0 && e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
        m_ri = m_wi;
      end
      if (done_ev) m_wi = -1;
    end
    if (rd_frame_done && m_mode == 2) begin
      if (m_ri >= 0) begin m_rdi = m_ri; m_ri = -1; end
      else if (e_rep != 16'hFFFF) e_rep = e_rep + 16'd1;
      e_cfg_addr = m_base + 32'(m_rdi) * m_pitch;
      e_rd_idx = 2'(m_rdi);
      e_lines = ctrl_frame_lines; e_stride = ctrl_line_stride; e_words = ctrl_line_words;
    end
    if (rd_frame_done && m_mode == 3) e_active = 1'b0;
    if (m_mode == 0 && ctrl_enable) begin
      m_base = ctrl_base_addr; m_pitch = ctrl_frame_bytes;
      m_lines = ctrl_frame_lines; m_stride = ctrl_line_stride; m_words = ctrl_line_words;
      nmode = 1;
    end
    if ((m_mode == 1 || m_mode == 2) && !ctrl_enable) nmode = 3;
    if (m_mode == 3 && m_wi < 0 && !old_active) begin
      nmode = 0; m_ri = -1; m_rdi = -1; e_rd_idx = 2'd0; e_wr_idx = 2'd0;
    end
    // A write completing during drain is still a completed write.
    if (m_mode == 3 && wr_done && m_wi >= 0) begin
      if (m_ri >= 0 && e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
      m_ri = m_wi; m_wi = -1;
    end
    m_mode = nmode;
    e_busy = (nmode != 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("wr_grant", 32'(wr_grant), 32'(e_grant));
    chk("wr_addr", wr_addr, e_wr_addr);
    chk("cfg_active", 32'(cfg_active), 32'(e_active));
    chk("cfg_frame_addr", cfg_frame_addr, e_cfg_addr);
    chk("cfg_frame_lines", 32'(cfg_frame_lines), 32'(e_lines));
    chk("cfg_line_stride", 32'(cfg_line_stride), 32'(e_stride));
    chk("cfg_line_words", 32'(cfg_line_words), 32'(e_words));
    chk("stat_rd_idx", 32'(stat_rd_idx), 32'(e_rd_idx));
    chk("stat_wr_idx", 32'(stat_wr_idx), 32'(e_wr_idx));
    chk("stat_drop_cnt", 32'(stat_drop_cnt), 32'(e_drop));
    chk("stat_rep_cnt", 32'(stat_rep_cnt), 32'(e_rep));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
    check_all();
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge aclk);
    #1;
    check_all();
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // Basic bring-up
    ctrl_enable = 1'b1; tick();
    chk("busy_after_enable", 32'(busy), 32'd1);
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    chk("grant0_pulse", 32'(wr_grant), 32'd1);
    chk("grant0_addr", wr_addr, 32'h1000_0000);
    tick();
    chk("grant0_one_cycle", 32'(wr_grant), 32'd0);
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk("first_cfg_addr", cfg_frame_addr, 32'h1000_0000);
    chk("first_active", 32'(cfg_active), 32'd1);
    chk("first_lines", 32'(cfg_frame_lines), 32'd480);
    wr_req = 1'b1; tick();
    chk("grant1_addr", wr_addr, 32'h1010_0000);
    chk("grant1_idx", 32'(stat_wr_idx), 32'd1);
    repeat (2) tick();
    wr_req = 1'b0;
    chk("held_req_no_grant", 32'(wr_grant), 32'd0);

    // Writer faster than reader
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    chk("grant2_addr", wr_addr, 32'h1020_0000);
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk("drop_one", 32'(stat_drop_cnt), 32'd1);
    tick();
    rd_frame_done = 1'b1; tick(); rd_frame_done = 1'b0;
    chk("newest_addr", cfg_frame_addr, 32'h1020_0000);
    chk("newest_idx", 32'(stat_rd_idx), 32'd2);

    // Reader faster, geometry re-latched only at a frame edge
    ctrl_frame_lines = 12'd240; tick(); tick();
    chk("lines_hold_midframe", 32'(cfg_frame_lines), 32'd480);
    rd_frame_done = 1'b1; tick(); rd_frame_done = 1'b0;
    chk("lines_at_boundary", 32'(cfg_frame_lines), 32'd240);
    tick();
    rd_frame_done = 1'b1; tick(); rd_frame_done = 1'b0;
    chk("rep_two", 32'(stat_rep_cnt), 32'd2);
    chk("rep_addr_kept", cfg_frame_addr, 32'h1020_0000);

    // Same-cycle wr_done and rd_frame_done
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    chk("grant_idx0_again", wr_addr, 32'h1000_0000);
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    chk("grant_idx1_again", wr_addr, 32'h1010_0000);
    wr_done = 1'b1; rd_frame_done = 1'b1; tick(); wr_done = 1'b0; rd_frame_done = 1'b0;
    chk("simul_cfg_addr", cfg_frame_addr, 32'h1010_0000);
    chk("simul_drop", 32'(stat_drop_cnt), 32'd2);
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    chk("simul_freed_grant", wr_addr, 32'h1000_0000);

    // Disable while buffer 0 is being written
    ctrl_enable = 1'b0; tick();
    wr_req = 1'b1; tick(); tick();
    chk("drain_no_grant", 32'(wr_grant), 32'd0);
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    tick(); tick();
    chk("drain_busy_held", 32'(busy), 32'd1);
    chk("drain_active_held", 32'(cfg_active), 32'd1);
    rd_frame_done = 1'b1; tick(); rd_frame_done = 1'b0;
    chk("drain_active_low", 32'(cfg_active), 32'd0);
    tick();
    chk("drain_idle", 32'(busy), 32'd0);
    wr_req = 1'b0;
    ctrl_enable = 1'b1; tick();
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    chk("reenable_all_free", wr_addr, 32'h1000_0000);
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    wr_req = 1'b1; tick(); wr_req = 1'b0;

    // Asynchronous reset while running
    #2 rst = 1'b0;
    #1;
    chk("async_active", 32'(cfg_active), 32'd0);
    chk("async_cfg_addr", cfg_frame_addr, 32'd0);
    chk("async_wr_addr", wr_addr, 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_drop", 32'(stat_drop_cnt), 32'd0);
    chk("async_rep", 32'(stat_rep_cnt), 32'd0);
    chk("async_wr_idx", 32'(stat_wr_idx), 32'd0);
    m_reset();
    @(posedge aclk);
    #1;
    check_all();
    rst = 1'b1;
    tick();
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    chk("restart_grant_idx0", wr_addr, 32'h1000_0000);
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk("restart_cfg_addr", cfg_frame_addr, 32'h1000_0000);
    chk("restart_active", 32'(cfg_active), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
